// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b000101;
  localparam logic [5:0] OPC_J   = 6'b000010;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HELD
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that returned while decode was stalled.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               consume,
  input  logic               clear,
  input  logic [INSTR_W-1:0] loadData,
  output logic [INSTR_W-1:0] bufData,
  output logic               bufValid
);

  // Clear wins over load so a redirect never leaves a stale word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufData  <= NOP_INSTR;
      bufValid <= 1'b0;
    end else if (clear) begin
      bufValid <= 1'b0;
    end else if (load) begin
      bufData  <= loadData;
      bufValid <= 1'b1;
    end else if (consume) begin
      bufValid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage plus IF/ID register: PC sequencing, stall/redirect handling and
// a req/ready handshake to a variable-latency instruction memory.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imemAddr,
  output logic               imemReq,
  input  logic [INSTR_W-1:0] imemInstr,
  input  logic               imemReady,
  input  logic               stall,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jumpTarget,
  output logic [INSTR_W-1:0] ifidInstr,
  output logic [ADDR_W-1:0]  ifidPC,
  output logic               ifidValid,
  output logic [5:0]         opcode
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcPlus4;
  logic [ADDR_W-1:0] rawTarget;
  logic [ADDR_W-1:0] redirTarget;
  logic              redirect;
  logic              pendValid;
  logic [ADDR_W-1:0] pendTarget;
  logic              bufLoad;
  logic              bufConsume;
  logic              bufClear;
  logic [INSTR_W-1:0] bufData;
  logic              bufValid;

  assign redirect    = branchTaken | jump;
  assign rawTarget   = branchTaken ? branchTarget : jumpTarget;
  assign redirTarget = {rawTarget[ADDR_W-1:2], 2'b00};
  assign pcPlus4     = pc + ADDR_W'(4);
  assign imemAddr    = pc;
  assign opcode      = opcode_of(ifidInstr);

  assign bufLoad    = (state == WAIT) && stall && imemReady;
  assign bufConsume = (state == HELD) && !stall && !redirect && !pendValid;
  assign bufClear   = (state == HELD) && !stall && (redirect || pendValid);

  // In WAIT the address must stay put even under stall, so the request stays up.
  always_comb begin
    imemReq = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH:   imemReq = ~stall;
        WAIT:    imemReq = 1'b1;
        default: imemReq = 1'b0;
      endcase
    end
  end

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bufLoad),
    .consume  (bufConsume),
    .clear    (bufClear),
    .loadData (imemInstr),
    .bufData  (bufData),
    .bufValid (bufValid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ifidInstr  <= NOP_INSTR;
      ifidPC     <= '0;
      ifidValid  <= 1'b0;
      pendValid  <= 1'b0;
      pendTarget <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            if (redirect) begin
              pc        <= redirTarget;
              ifidInstr <= NOP_INSTR;
              ifidValid <= 1'b0;
            end else if (imemReady) begin
              ifidInstr <= imemInstr;
              ifidPC    <= pcPlus4;
              ifidValid <= 1'b1;
              pc        <= pcPlus4;
            end else begin
              ifidInstr <= NOP_INSTR;
              ifidValid <= 1'b0;
              state     <= WAIT;
            end
          end
        end

        WAIT: begin
          if (stall) begin
            if (imemReady) state <= HELD;
          end else if (redirect && imemReady) begin
            // The response completes this cycle, so redirect directly instead of parking it.
            pc        <= redirTarget;
            pendValid <= 1'b0;
            ifidInstr <= NOP_INSTR;
            ifidValid <= 1'b0;
            state     <= FETCH;
          end else if (redirect) begin
            pendValid  <= 1'b1;
            pendTarget <= redirTarget;
            ifidInstr  <= NOP_INSTR;
            ifidValid  <= 1'b0;
          end else if (imemReady) begin
            if (pendValid) begin
              pc        <= pendTarget;
              pendValid <= 1'b0;
              ifidInstr <= NOP_INSTR;
              ifidValid <= 1'b0;
            end else begin
              ifidInstr <= imemInstr;
              ifidPC    <= pcPlus4;
              ifidValid <= 1'b1;
              pc        <= pcPlus4;
            end
            state <= FETCH;
          end else begin
            ifidInstr <= NOP_INSTR;
            ifidValid <= 1'b0;
          end
        end

        HELD: begin
          if (!stall) begin
            if (redirect) begin
              pc        <= redirTarget;
              pendValid <= 1'b0;
              ifidInstr <= NOP_INSTR;
              ifidValid <= 1'b0;
            end else if (pendValid) begin
              pc        <= pendTarget;
              pendValid <= 1'b0;
              ifidInstr <= NOP_INSTR;
              ifidValid <= 1'b0;
            end else begin
              ifidInstr <= bufData;
              ifidPC    <= pcPlus4;
              ifidValid <= bufValid;
              pc        <= pcPlus4;
            end
            state <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
